// File: rtl/sayeh_pkg.sv
// Shared types and defaults for the SAYEH memory bus stage.
package sayeh_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 16;
  localparam int TIMEOUT_CYC_DEF = 15;

endpackage

// File: rtl/mem_bus_watchdog.sv
// Access watchdog: counts un-acked ACCESS cycles and flags expiry.
// Only built when MEM_BUS_TIMEOUT_EN is defined.
`ifdef MEM_BUS_TIMEOUT_EN
module mem_bus_watchdog #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 8'd1;
  end

  // Fires in the cycle whose increment would reach TIMEOUT_CYC, so mem_req
  // is held for exactly TIMEOUT_CYC cycles before the abort.
  assign expired = en && (cnt == LAST);

endmodule
`endif

// File: rtl/mem_bus_interface.sv
// Memory-side req/ack stage behind the SAYEH addressing unit.
// Optional watchdog abort enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_interface
  import sayeh_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              readMem,
  input  logic              writeMem,
  output logic [DATA_W-1:0] DataOut,
  output logic              memDataReady,
  output logic              busy,
  output logic              memError,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  mem_state_t state, state_nxt;
  logic accept, illegal, done_ok, timeout, expired;

`ifdef MEM_BUS_TIMEOUT_EN
  mem_bus_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      ((state == ACCESS) && !mem_ack),
    .expired (expired)
  );
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYC);
  assign expired        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    illegal   = 1'b0;
    done_ok   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (readMem ^ writeMem) begin
          accept    = 1'b1;
          state_nxt = ACCESS;
        end else if (readMem && writeMem) begin
          illegal = 1'b1;
        end
      end
      ACCESS: begin
        // ack takes priority over a simultaneous watchdog expiry
        if (mem_ack) begin
          done_ok   = 1'b1;
          state_nxt = DONE;
        end else if (expired) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DataOut      <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      memDataReady <= 1'b0;
      memError     <= 1'b0;
    end else begin
      memDataReady <= illegal | done_ok | timeout;
      if (accept) begin
        mem_addr  <= Address;
        mem_wdata <= DataIn;
        mem_we    <= writeMem;
        mem_req   <= 1'b1;
        memError  <= 1'b0;
      end
      if (illegal) memError <= 1'b1;
      if (done_ok) begin
        mem_req <= 1'b0;
        if (!mem_we) DataOut <= mem_rdata;
      end
      if (timeout) begin
        mem_req  <= 1'b0;
        memError <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_interface.sv
// Directed + randomized bench for mem_bus_interface against a transaction-level model.
module tb_mem_bus_interface;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] Address, DataIn, DataOut, mem_addr, mem_wdata, mem_rdata;
  logic        readMem, writeMem, memDataReady, busy, memError;
  logic        mem_req, mem_we, mem_ack;

  int checks   = 0;
  int failures = 0;
  int txns     = 0;

  // model state: last read data and sticky error
  logic [15:0] m_dout;
  logic        m_err;

  always #5 clk = ~clk;

  mem_bus_interface #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .Address(Address), .DataIn(DataIn),
    .readMem(readMem), .writeMem(writeMem), .DataOut(DataOut),
    .memDataReady(memDataReady), .busy(busy), .memError(memError),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always @(posedge clk) if (rst_n && mem_req && mem_ack) txns++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"},  DataOut, 0);
    chk({tag, "_addr"},  mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_req"},   mem_req, 0);
    chk({tag, "_we"},    mem_we, 0);
    chk({tag, "_rdy"},   memDataReady, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_err"},   memError, 0);
  endtask

  // One controller request starting at a negedge in IDLE; memory acks after 'waits' extra cycles.
  task automatic access(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] rdat, input int waits, input bit stray);
    Address = a; DataIn = d; readMem = rd; writeMem = wr;
    @(negedge clk);
    readMem = 1'b0; writeMem = 1'b0;
    if (rd && wr) begin
      m_err = 1'b1;
      chk("ill_req",  mem_req, 0);
      chk("ill_err",  memError, m_err);
      chk("ill_rdy",  memDataReady, 1);
      chk("ill_busy", busy, 0);
      chk("ill_dout", DataOut, m_dout);
      @(negedge clk);
      chk("ill_rdy_off", memDataReady, 0);
      return;
    end
    m_err = 1'b0;
    chk("acc_req",   mem_req, 1);
    chk("acc_addr",  mem_addr, a);
    chk("acc_we",    mem_we, wr);
    chk("acc_wdata", mem_wdata, d);
    chk("acc_err",   memError, m_err);
    chk("acc_busy",  busy, 1);
    for (int i = 0; i < waits; i++) begin
      readMem = stray && (i == 0);
      Address = $urandom; DataIn = $urandom;
      @(negedge clk);
      readMem = 1'b0;
      chk("wait_req",  mem_req, 1);
      chk("wait_addr", mem_addr, a);
      chk("wait_rdy",  memDataReady, 0);
    end
    mem_ack = 1'b1; mem_rdata = rdat;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = $urandom;
    if (rd) m_dout = rdat;
    chk("done_req",  mem_req, 0);
    chk("done_rdy",  memDataReady, 1);
    chk("done_busy", busy, 1);
    chk("done_dout", DataOut, m_dout);
    chk("done_err",  memError, m_err);
    @(negedge clk);
    chk("idle_rdy",  memDataReady, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; Address = '0; DataIn = '0; readMem = 1'b0; writeMem = 1'b0;
    mem_rdata = '0; mem_ack = 1'b0;
    m_dout = '0; m_err = 1'b0;
    #1 chk_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // read with two wait states, then zero-wait write
    access(1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 2, 1'b0);
    chk("rd_dout", DataOut, 16'hBEEF);
    access(1'b0, 1'b1, 16'h1234, 16'hA5A5, 16'h5555, 0, 1'b0);
    chk("wr_dout_hold", DataOut, 16'hBEEF);

    // illegal request then legal read clears the error
    access(1'b1, 1'b1, 16'h0001, 16'h0002, 16'h0, 0, 1'b0);
    chk("ill_state_idle", busy, 0);
    access(1'b1, 1'b0, 16'h0002, 16'h0000, 16'h1111, 1, 1'b0);

    // stray ack in IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack_busy", busy, 0);
    chk("stray_ack_rdy",  memDataReady, 0);
    chk("stray_ack_dout", DataOut, m_dout);

    // reset mid-access
    Address = 16'h7777; readMem = 1'b1;
    @(negedge clk);
    readMem = 1'b0;
    chk("mid_req_up", mem_req, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    m_dout = '0; m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b1, 1'b0, 16'h0100, 16'h0000, 16'hCAFE, 1, 1'b0);

    // back-to-back with a stray readMem during ACCESS
    t0 = txns;
    access(1'b1, 1'b0, 16'h0200, 16'h0000, 16'h2468, 2, 1'b1);
    access(1'b0, 1'b1, 16'h0204, 16'h9999, 16'h0000, 1, 1'b0);
    chk("b2b_txns", txns - t0, 2);

    // stalled read
    Address = 16'h0300; readMem = 1'b1;
    @(negedge clk);
    readMem = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
    chk("to_req1", mem_req, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("to_req_hold", mem_req, 1);
    end
    @(negedge clk);
    m_err = 1'b1;
    chk("to_req_drop", mem_req, 0);
    chk("to_err",      memError, m_err);
    chk("to_rdy",      memDataReady, 1);
    chk("to_dout",     DataOut, m_dout);
    @(negedge clk);
    chk("to_idle", busy, 0);
    access(1'b1, 1'b0, 16'h0304, 16'h0000, 16'h0F0F, 0, 1'b0);
`else
    begin
      int busy_cycles = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (busy === 1'b1 && mem_req === 1'b1) busy_cycles++;
      end
      chk("stall_busy_cycles", busy_cycles, 100);
      chk("stall_err", memError, 0);
    end
    rst_n = 1'b0;
    m_dout = '0; m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      int op;
      op = $urandom_range(0, 4);
      access(op < 2, (op >= 2), 16'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(0, 3), 1'b0);
      chk("rnd_err", memError, m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
